// File: rtl/vga_pkg.sv
// Shared timing defaults and state encodings for the VGA timing generator.
package vga_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   typedef enum logic [1:0] {ACT, FP, SYNC, BP} axis_state_t;

   typedef enum logic {FETCH_IDLE, FETCH_WAIT} fetch_state_t;

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: position counter plus ACT/FP/SYNC/BP phase FSM, stepping when adv is high.
module vga_axis_timer
   import vga_pkg::*;
#(
   parameter int ACT_LEN   = DEF_H_ACTIVE,
   parameter int FRONT_LEN = DEF_H_FRONT,
   parameter int SYNC_LEN  = DEF_H_SYNC,
   parameter int BACK_LEN  = DEF_H_BACK
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        adv,
   output logic        wrap,
   output logic [9:0]  next_count,
   output axis_state_t next_state
);

   localparam int TOTAL = ACT_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
   localparam logic [9:0] LAST_ACT   = 10'(ACT_LEN - 1);
   localparam logic [9:0] LAST_FRONT = 10'(ACT_LEN + FRONT_LEN - 1);
   localparam logic [9:0] LAST_SYNC  = 10'(ACT_LEN + FRONT_LEN + SYNC_LEN - 1);
   localparam logic [9:0] LAST_POS   = 10'(TOTAL - 1);

   logic [9:0]  count;
   axis_state_t state;

   // Reset parks the axis on its last position so the first step lands on 0 in ACT.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= LAST_POS;
         state <= BP;
      end else begin
         count <= next_count;
         state <= next_state;
      end
   end

   always_comb begin
      next_count = count;
      next_state = state;
      if (adv) begin
         next_count = (count == LAST_POS) ? 10'd0 : count + 10'd1;
         case (state)
            ACT:     if (count == LAST_ACT)   next_state = FP;
            FP:      if (count == LAST_FRONT) next_state = SYNC;
            SYNC:    if (count == LAST_SYNC)  next_state = BP;
            BP:      if (count == LAST_POS)   next_state = ACT;
            default: next_state = BP;
         endcase
      end
   end

   assign wrap = adv && (count == LAST_POS);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA sync/position generator with an optional per-line fetch handshake.
// The fetch logic is built only when VGA_FETCH_EN is defined; otherwise its outputs are tied low.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK
) (
   input  logic       clk25,
   input  logic       rst,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_start,
   output logic       fetch_req,
   output logic [9:0] fetch_line,
   input  logic       fetch_ack,
   output logic       fetch_err
);

   logic        h_wrap;
   logic        v_wrap_unused;
   logic [9:0]  h_next_count;
   logic [9:0]  v_next_count;
   axis_state_t h_next_state;
   axis_state_t v_next_state;

   vga_axis_timer #(
      .ACT_LEN   (H_ACTIVE),
      .FRONT_LEN (H_FRONT),
      .SYNC_LEN  (H_SYNC),
      .BACK_LEN  (H_BACK)
   ) h_timer (
      .clk        (clk25),
      .rst        (rst),
      .adv        (1'b1),
      .wrap       (h_wrap),
      .next_count (h_next_count),
      .next_state (h_next_state)
   );

   vga_axis_timer #(
      .ACT_LEN   (V_ACTIVE),
      .FRONT_LEN (V_FRONT),
      .SYNC_LEN  (V_SYNC),
      .BACK_LEN  (V_BACK)
   ) v_timer (
      .clk        (clk25),
      .rst        (rst),
      .adv        (h_wrap),
      .wrap       (v_wrap_unused),
      .next_count (v_next_count),
      .next_state (v_next_state)
   );

   // Outputs are registered from the timers' next values so they line up with the position.
   always_ff @(posedge clk25) begin
      if (rst) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         video_on    <= 1'b0;
         pixel_x     <= 10'd0;
         pixel_y     <= 10'd0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= (h_next_state != SYNC);
         vsync       <= (v_next_state != SYNC);
         video_on    <= (h_next_state == ACT) && (v_next_state == ACT);
         pixel_x     <= h_next_count;
         pixel_y     <= v_next_count;
         frame_start <= (h_next_count == 10'd0) && (v_next_count == 10'd0);
      end
   end

`ifdef VGA_FETCH_EN
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [9:0] FETCH_X = 10'(H_ACTIVE);
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_LIMIT = 10'(V_ACTIVE);

   fetch_state_t fetch_state;
   fetch_state_t fetch_state_next;
   logic [9:0]   fetch_line_next;
   logic         fetch_err_next;
   logic [9:0]   upcoming_line;

   assign upcoming_line = (v_next_count == V_LAST) ? 10'd0 : v_next_count + 10'd1;

   always_ff @(posedge clk25) begin
      if (rst) begin
         fetch_state <= FETCH_IDLE;
         fetch_line  <= 10'd0;
         fetch_err   <= 1'b0;
      end else begin
         fetch_state <= fetch_state_next;
         fetch_line  <= fetch_line_next;
         fetch_err   <= fetch_err_next;
      end
   end

   // A request that is still unanswered on the last pixel of its line is abandoned and flagged.
   always_comb begin
      fetch_state_next = fetch_state;
      fetch_line_next  = fetch_line;
      fetch_err_next   = fetch_err;
      case (fetch_state)
         FETCH_IDLE: begin
            if ((h_next_count == FETCH_X) && (upcoming_line < V_LIMIT)) begin
               fetch_state_next = FETCH_WAIT;
               fetch_line_next  = upcoming_line;
            end
         end
         FETCH_WAIT: begin
            if (fetch_ack) begin
               fetch_state_next = FETCH_IDLE;
            end else if (pixel_x == H_LAST) begin
               fetch_state_next = FETCH_IDLE;
               fetch_err_next   = 1'b1;
            end
         end
         default: fetch_state_next = FETCH_IDLE;
      endcase
   end

   assign fetch_req = (fetch_state == FETCH_WAIT);
`else
   logic fetch_ack_unused;

   assign fetch_ack_unused = fetch_ack;
   assign fetch_req        = 1'b0;
   assign fetch_line       = 10'd0;
   assign fetch_err        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: a default-geometry instance for line timing and a
// reduced-geometry instance (16x10 total) for frame, fetch and reset behaviour; honours VGA_FETCH_EN.
module tb_vga_timing_ctrl;

   logic       clk25 = 1'b0;
   logic       rst;
   logic       ack_d, ack_s;
   logic       hsync_d, vsync_d, video_on_d, frame_start_d, fetch_req_d, fetch_err_d;
   logic [9:0] pixel_x_d, pixel_y_d, fetch_line_d;
   logic       hsync_s, vsync_s, video_on_s, frame_start_s, fetch_req_s, fetch_err_s;
   logic [9:0] pixel_x_s, pixel_y_s, fetch_line_s;

   int compared   = 0;
   int mismatched = 0;

   localparam logic [35:0] RESET_WORD = {6'b110000, 30'd0};

   always #5 clk25 = ~clk25;

   vga_timing_ctrl dut_d (
      .clk25(clk25), .rst(rst), .hsync(hsync_d), .vsync(vsync_d), .video_on(video_on_d),
      .pixel_x(pixel_x_d), .pixel_y(pixel_y_d), .frame_start(frame_start_d),
      .fetch_req(fetch_req_d), .fetch_line(fetch_line_d), .fetch_ack(ack_d), .fetch_err(fetch_err_d)
   );

   vga_timing_ctrl #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut_s (
      .clk25(clk25), .rst(rst), .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s),
      .pixel_x(pixel_x_s), .pixel_y(pixel_y_s), .frame_start(frame_start_s),
      .fetch_req(fetch_req_s), .fetch_line(fetch_line_s), .fetch_ack(ack_s), .fetch_err(fetch_err_s)
   );

   task automatic check_output(input string tag, input logic [39:0] observed, input logic [39:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic check_reset_s(input string tag);
      check_output(tag, {4'd0, hsync_s, vsync_s, video_on_s, frame_start_s, fetch_req_s, fetch_err_s,
                         pixel_x_s, pixel_y_s, fetch_line_s}, {4'd0, RESET_WORD});
   endtask

   initial begin
      int fs_cnt, fs_at, hs_cnt, hs_first, vs_cnt, vs_first, vo_cnt, vo_last, vo_bad;
      int rq_cnt, rq_first, rq_line, rq_sum, rq_bad, nz_cnt;

      rst   = 1'b1;
      ack_d = 1'b1;
      ack_s = 1'b1;
      repeat (3) @(negedge clk25);
      check_output("reset_d", {4'd0, hsync_d, vsync_d, video_on_d, frame_start_d, fetch_req_d,
                   fetch_err_d, pixel_x_d, pixel_y_d, fetch_line_d}, {4'd0, RESET_WORD});
      check_reset_s("reset_s");

      // Default geometry, fetch_ack tied high: lines 0 and 1.
      rst = 1'b0;
      fs_cnt = 0; hs_cnt = 0; hs_first = -1; vo_cnt = 0; vo_last = -1;
      rq_cnt = 0; rq_first = -1; rq_line = 0; nz_cnt = 0;
      for (int c = 0; c < 1600; c++) begin
         @(negedge clk25);
         if (c == 0)
            check_output("start_d", {frame_start_d, video_on_d, pixel_x_d, pixel_y_d}, {2'b11, 20'd0});
         if (c == 799) check_output("x_last_d", pixel_x_d, 40'd799);
         if (c == 800) check_output("wrap_d", {pixel_x_d, pixel_y_d}, {10'd0, 10'd1});
         if (frame_start_d) fs_cnt++;
         if (c < 800) begin
            if (!hsync_d) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = c;
            end
            if (video_on_d) begin
               vo_cnt++;
               vo_last = c;
            end
         end
         if (fetch_req_d) begin
            rq_cnt++;
            if (rq_first < 0) begin
               rq_first = c;
               rq_line  = int'(fetch_line_d);
            end
         end
         if (fetch_req_d || fetch_err_d || (fetch_line_d != 10'd0)) nz_cnt++;
      end
      check_output("frame_start_cnt_d", 40'(fs_cnt), 40'd1);
      check_output("hsync_low_cnt_d", 40'(hs_cnt), 40'd96);
      check_output("hsync_first_x_d", 40'(hs_first), 40'd656);
      check_output("video_cnt_d", 40'(vo_cnt), 40'd640);
      check_output("video_last_x_d", 40'(vo_last), 40'd639);
`ifdef VGA_FETCH_EN
      check_output("req_cnt_d", 40'(rq_cnt), 40'd2);
      check_output("req_first_x_d", 40'(rq_first), 40'd640);
      check_output("req_first_line_d", 40'(rq_line), 40'd1);
      check_output("err_d", 40'(fetch_err_d), 40'd0);
`else
      check_output("fetch_tied_d", 40'(nz_cnt), 40'd0);
`endif

      // Reduced geometry: reset mid-frame, then two frames with fetch_ack tied high.
      rst = 1'b1;
      repeat (2) @(negedge clk25);
      check_reset_s("reset_midframe_s");
      rst = 1'b0;
      fs_cnt = 0; fs_at = -1; vs_cnt = 0; vs_first = -1; vo_cnt = 0; vo_bad = 0;
      rq_cnt = 0; rq_sum = 0; rq_bad = 0; nz_cnt = 0;
      for (int c = 0; c < 320; c++) begin
         @(negedge clk25);
         if (c == 0)
            check_output("start_s", {frame_start_s, video_on_s, pixel_x_s, pixel_y_s}, {2'b11, 20'd0});
         if (frame_start_s && (c > 0)) begin
            fs_cnt++;
            fs_at = c;
         end
         if (c < 160) begin
            if (!vsync_s) begin
               vs_cnt++;
               if (vs_first < 0) vs_first = c;
            end
            if (video_on_s) vo_cnt++;
            if (video_on_s && (c >= 96)) vo_bad++;
            if (fetch_req_s) begin
               rq_cnt++;
               rq_sum += int'(fetch_line_s);
               if ((c % 16) != 8) rq_bad++;
            end
         end
         if (fetch_req_s || fetch_err_s || (fetch_line_s != 10'd0)) nz_cnt++;
      end
      check_output("frame_start_again_cnt_s", 40'(fs_cnt), 40'd1);
      check_output("frame_start_again_at_s", 40'(fs_at), 40'd160);
      check_output("vsync_low_cnt_s", 40'(vs_cnt), 40'd32);
      check_output("vsync_first_s", 40'(vs_first), 40'd112);
      check_output("video_cnt_s", 40'(vo_cnt), 40'd48);
      check_output("video_blank_lines_s", 40'(vo_bad), 40'd0);
`ifdef VGA_FETCH_EN
      check_output("req_cnt_s", 40'(rq_cnt), 40'd6);
      check_output("req_line_sum_s", 40'(rq_sum), 40'd15);
      check_output("req_off_x_s", 40'(rq_bad), 40'd0);
      check_output("err_clean_s", 40'(fetch_err_s), 40'd0);
`else
      check_output("fetch_tied_s", 40'(nz_cnt), 40'd0);
`endif

      // Reduced geometry: line 2 request times out, line 3 acked on its last pixel.
      rst = 1'b1;
      repeat (2) @(negedge clk25);
      rst = 1'b0;
      nz_cnt = 0;
      for (int c = 0; c < 101; c++) begin
         @(negedge clk25);
`ifdef VGA_FETCH_EN
         case (c)
            31:  check_output("err_before_s", 40'(fetch_err_s), 40'd0);
            47:  check_output("hold_last_x_s", {fetch_req_s, fetch_line_s, fetch_err_s}, {1'b1, 10'd3, 1'b0});
            48:  check_output("timeout_s", {fetch_req_s, fetch_err_s}, {1'b0, 1'b1});
            56:  check_output("req_after_err_s", {fetch_req_s, fetch_line_s}, {1'b1, 10'd4});
            63:  check_output("hold_ack_last_s", {fetch_req_s, fetch_line_s}, {1'b1, 10'd4});
            64:  check_output("ack_last_drop_s", 40'(fetch_req_s), 40'd0);
            72:  check_output("req_line5_s", {fetch_req_s, fetch_line_s}, {1'b1, 10'd5});
            73:  check_output("ack_drop_s", 40'(fetch_req_s), 40'd0);
            100: check_output("err_sticky_s", 40'(fetch_err_s), 40'd1);
            default: ;
         endcase
`endif
         if (fetch_req_s || fetch_err_s || (fetch_line_s != 10'd0)) nz_cnt++;
         ack_s = (c < 32) || (c >= 63);
      end
`ifndef VGA_FETCH_EN
      check_output("ack_ignored_s", 40'(nz_cnt), 40'd0);
`endif

      // Reduced geometry: reset while a request is pending at (9,2).
      rst = 1'b1;
      repeat (2) @(negedge clk25);
      rst   = 1'b0;
      ack_s = 1'b0;
      for (int c = 0; c < 42; c++) begin
         @(negedge clk25);
`ifdef VGA_FETCH_EN
         if (c == 41)
            check_output("pending_s", {fetch_req_s, fetch_line_s, fetch_err_s}, {1'b1, 10'd3, 1'b1});
`endif
      end
      check_output("pos_before_rst_s", {pixel_x_s, pixel_y_s}, {10'd9, 10'd2});
      rst = 1'b1;
      @(negedge clk25);
      check_reset_s("reset_handshake_s");
      rst = 1'b0;
      @(negedge clk25);
      check_output("restart_s", {frame_start_s, video_on_s, fetch_req_s, fetch_err_s, pixel_x_s, pixel_y_s},
                   {4'b1100, 20'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
